// File: rtl/sd_sector_buffer_pkg.sv
// Shared definitions for the SD sector buffer: FSM encoding and sector geometry.
package sd_sector_buffer_pkg;

   localparam int unsigned SD_SECTOR_BYTES = 512;
   localparam int unsigned SSB_TMR_W       = 25;

   typedef enum logic [1:0] {
      SSB_IDLE  = 2'd0,
      SSB_ISSUE = 2'd1,
      SSB_FILL  = 2'd2,
      SSB_DONE  = 2'd3
   } ssb_state_e;

endpackage

// File: rtl/sd_sector_buffer_if.sv
// Bus-side and SD-controller-side signals of the sector buffer; slave = buffer view.
interface sd_sector_buffer_if #(
   parameter int unsigned IDX_W = 9
);
   logic             cmd_read;
   logic [31:0]      cmd_addr;
   logic             sd_ready;
   logic             sd_byte_available;
   logic [7:0]       sd_dout;
   logic             sd_rd;
   logic [31:0]      sd_address;
   logic [IDX_W-1:0] rd_index;
   logic [7:0]       rd_data;
   logic             sector_valid;
   logic             busy;
   logic             error;

   modport slave (
      input  cmd_read, cmd_addr, sd_ready, sd_byte_available, sd_dout, rd_index,
      output sd_rd, sd_address, rd_data, sector_valid, busy, error
   );

   modport master (
      output cmd_read, cmd_addr, sd_ready, sd_byte_available, sd_dout, rd_index,
      input  sd_rd, sd_address, rd_data, sector_valid, busy, error
   );
endinterface

// File: rtl/sd_sector_buffer_ram.sv
// Single-clock 1W/1R byte RAM, read-first, registered output, no reset (maps to block RAM).
module ssb_byte_ram #(
   parameter int unsigned DEPTH = 512,
   parameter int unsigned AW    = 9
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [7:0]    i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [7:0]    o_rdata
);
   logic [7:0] r_mem [DEPTH];
   logic [7:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/sd_sector_buffer.sv
// Sector read sequencer + capture buffer between sd_controller and the CPU bus.
// Optional idle-byte timeout: define SD_SECTOR_BUFFER_TIMEOUT_EN.
module sd_sector_buffer
   import sd_sector_buffer_pkg::*;
#(
   parameter int unsigned SECTOR_BYTES   = SD_SECTOR_BYTES,
   parameter int unsigned IDX_W          = 9
`ifdef SD_SECTOR_BUFFER_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 25_000_000
`endif
) (
   input logic                clk,
   input logic                reset_n,
   sd_sector_buffer_if.slave  bus
);
   ssb_state_e       r_state, w_state_nxt;
   logic [IDX_W-1:0] r_count;
   logic             r_byte_av_d;
   logic [31:0]      r_sd_address;
   logic             r_sector_valid, r_busy, r_error, r_rd_en;
   logic             w_rise, w_sd_rd, w_accept, w_drop, w_we, w_last;
   logic             w_timeout, w_tmo_hit;
   logic [7:0]       w_ram_q;

   assign w_rise = bus.sd_byte_available & ~r_byte_av_d;
   assign w_last = (r_count == '1);

`ifdef SD_SECTOR_BUFFER_TIMEOUT_EN
   logic [SSB_TMR_W-1:0] r_timer;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                       r_timer <= '0;
      else if (w_accept || w_we)                          r_timer <= '0;
      else if (r_state == SSB_ISSUE || r_state == SSB_FILL) r_timer <= r_timer + 1'b1;
   end

   assign w_tmo_hit = (r_state == SSB_ISSUE || r_state == SSB_FILL) &&
                      (r_timer == SSB_TMR_W'(TIMEOUT_CYCLES - 1));
`else
   assign w_tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= SSB_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sd_rd     = 1'b0;
      w_accept    = 1'b0;
      w_drop      = 1'b0;
      w_we        = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         SSB_IDLE, SSB_DONE: begin
            if (bus.cmd_read) begin
               w_accept    = 1'b1;
               w_state_nxt = SSB_ISSUE;
            end
         end
         SSB_ISSUE: begin
            w_drop = bus.cmd_read;
            if (bus.sd_ready) begin
               w_sd_rd     = 1'b1;
               w_state_nxt = SSB_FILL;
            end else if (w_tmo_hit) begin
               w_timeout   = 1'b1;
               w_state_nxt = SSB_IDLE;
            end
         end
         SSB_FILL: begin
            w_drop = bus.cmd_read;
            if (w_rise) begin
               w_we = 1'b1;
               if (w_last) w_state_nxt = SSB_DONE;
            end else if (w_tmo_hit) begin
               w_timeout   = 1'b1;
               w_state_nxt = SSB_IDLE;
            end
         end
         default: w_state_nxt = SSB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count        <= '0;
         r_byte_av_d    <= 1'b0;
         r_sd_address   <= '0;
         r_sector_valid <= 1'b0;
         r_busy         <= 1'b0;
         r_error        <= 1'b0;
         r_rd_en        <= 1'b0;
      end else begin
         r_byte_av_d <= bus.sd_byte_available;
         r_rd_en     <= 1'b1;
         if (w_accept) begin
            r_sd_address   <= bus.cmd_addr;
            r_sector_valid <= 1'b0;
            r_error        <= 1'b0;
            r_busy         <= 1'b1;
            r_count        <= '0;
         end
         if (w_drop) r_error <= 1'b1;
         if (w_we) begin
            r_count <= r_count + 1'b1;
            if (w_last) begin
               r_sector_valid <= 1'b1;
               r_busy         <= 1'b0;
            end
         end
         if (w_timeout) begin
            r_busy         <= 1'b0;
            r_sector_valid <= 1'b0;
            r_error        <= 1'b1;
         end
      end
   end

   ssb_byte_ram #(
      .DEPTH (SECTOR_BYTES),
      .AW    (IDX_W)
   ) u_ram (
      .i_clk   (clk),
      .i_we    (w_we),
      .i_waddr (r_count),
      .i_wdata (bus.sd_dout),
      .i_raddr (bus.rd_index),
      .o_rdata (w_ram_q)
   );

   // RAM output has no reset; mask it until the first post-reset read has landed
   assign bus.rd_data      = r_rd_en ? w_ram_q : '0;
   assign bus.sd_rd        = w_sd_rd;
   assign bus.sd_address   = r_sd_address;
   assign bus.sector_valid = r_sector_valid;
   assign bus.busy         = r_busy;
   assign bus.error        = r_error;
endmodule

// File: tb/tb_sd_sector_buffer.sv
// Directed bench for sd_sector_buffer; timeout vectors run when SD_SECTOR_BUFFER_TIMEOUT_EN is set.
module tb_sd_sector_buffer;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_vec = 0, n_err = 0, rd_pulses = 0, p0;

   always #5 clk = ~clk;

   sd_sector_buffer_if #(.IDX_W(9)) sif ();

   sd_sector_buffer #(
      .SECTOR_BYTES (512),
      .IDX_W        (9)
`ifdef SD_SECTOR_BUFFER_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (1000)
`endif
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (sif)
   );

   always @(posedge clk) if (sif.sd_rd) rd_pulses++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [31:0] a);
      sif.cmd_addr = a;
      sif.cmd_read = 1'b1;
      tick();
      sif.cmd_read = 1'b0;
      sif.cmd_addr = 32'hDEAD_BEEF;
   endtask

   task automatic stream_byte(input logic [7:0] v, input int hold);
      sif.sd_dout           = v;
      sif.sd_byte_available = 1'b1;
      repeat (hold) tick();
      sif.sd_byte_available = 1'b0;
      tick();
   endtask

   // bytes first..511 with value index^xr; checks sector_valid rises exactly on the last edge
   task automatic stream_sector(input int first, input logic [7:0] xr, input int hold);
      for (int i = first; i < 511; i++) stream_byte(8'(i) ^ xr, hold);
      chk("valid_before_last", {31'd0, sif.sector_valid}, 32'd0);
      sif.sd_dout           = 8'hFF ^ xr;
      sif.sd_byte_available = 1'b1;
      tick();
      chk("valid_after_last", {31'd0, sif.sector_valid}, 32'd1);
      chk("busy_after_last", {31'd0, sif.busy}, 32'd0);
      repeat (hold - 1) tick();
      sif.sd_byte_available = 1'b0;
      tick();
   endtask

   task automatic read_check(input string tag, input logic [8:0] idx, input logic [7:0] exp);
      sif.rd_index = idx;
      tick();
      chk(tag, {24'd0, sif.rd_data}, {24'd0, exp});
   endtask

   task automatic check_reset_outputs();
      chk("rst_sd_rd", {31'd0, sif.sd_rd}, 32'd0);
      chk("rst_sd_address", sif.sd_address, 32'd0);
      chk("rst_valid", {31'd0, sif.sector_valid}, 32'd0);
      chk("rst_busy", {31'd0, sif.busy}, 32'd0);
      chk("rst_error", {31'd0, sif.error}, 32'd0);
      chk("rst_rd_data", {24'd0, sif.rd_data}, 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      sif.cmd_read          = 1'b0;
      sif.cmd_addr          = '0;
      sif.sd_ready          = 1'b1;
      sif.sd_byte_available = 1'b0;
      sif.sd_dout           = '0;
      sif.rd_index          = '0;
      repeat (3) tick();
      check_reset_outputs();
      reset_n = 1'b1;
      tick();

      // normal read, strobes held 4 cycles
      p0 = rd_pulses;
      send_cmd(32'h0000_0010);
      chk("n_busy", {31'd0, sif.busy}, 32'd1);
      chk("n_addr", sif.sd_address, 32'h10);
      tick();
      stream_sector(0, 8'h00, 4);
      chk("n_rd_pulses", rd_pulses - p0, 32'd1);
      chk("n_error", {31'd0, sif.error}, 32'd0);
      read_check("n_rd_1ff", 9'h1FF, 8'hFF);
      read_check("n_rd_000", 9'h000, 8'h00);
      read_check("n_rd_0ab", 9'h0AB, 8'hAB);

      // delayed ready
      sif.sd_ready = 1'b0;
      p0 = rd_pulses;
      send_cmd(32'h0000_0030);
      repeat (100) tick();
      chk("dr_no_pulse", rd_pulses - p0, 32'd0);
      chk("dr_busy", {31'd0, sif.busy}, 32'd1);
      chk("dr_sd_rd_low", {31'd0, sif.sd_rd}, 32'd0);
      sif.sd_ready = 1'b1;
      #1;
      chk("dr_sd_rd_high", {31'd0, sif.sd_rd}, 32'd1);
      tick();
      chk("dr_one_pulse", rd_pulses - p0, 32'd1);
      chk("dr_sd_rd_drop", {31'd0, sif.sd_rd}, 32'd0);
      stream_sector(0, 8'h5A, 1);
      chk("dr_addr", sif.sd_address, 32'h30);
      read_check("dr_rd_010", 9'h010, 8'h4A);

      // command dropped while busy
      send_cmd(32'h0000_0010);
      tick();
      for (int i = 0; i < 100; i++) stream_byte(8'(i) ^ 8'hA5, 1);
      sif.cmd_addr = 32'h0000_0020;
      sif.cmd_read = 1'b1;
      tick();
      sif.cmd_read = 1'b0;
      chk("bd_error", {31'd0, sif.error}, 32'd1);
      chk("bd_addr_kept", sif.sd_address, 32'h10);
      chk("bd_busy", {31'd0, sif.busy}, 32'd1);
      stream_sector(100, 8'hA5, 1);
      chk("bd_error_sticky", {31'd0, sif.error}, 32'd1);
      read_check("bd_rd_064", 9'h064, 8'hC1);
      read_check("bd_rd_1ff", 9'h1FF, 8'h5A);

      // stray strobes in IDLE, then one held strobe in FILL
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) stream_byte(8'hEE, 1);
      chk("st_busy", {31'd0, sif.busy}, 32'd0);
      read_check("st_rd_000", 9'h000, 8'hA5);
      read_check("st_rd_001", 9'h001, 8'hA4);
      read_check("st_rd_002", 9'h002, 8'hA7);
      send_cmd(32'h0000_0040);
      tick();
      stream_byte(8'h11, 50);
      stream_sector(1, 8'h00, 1);
      read_check("st_rd_held", 9'h000, 8'h11);
      read_check("st_rd_next", 9'h001, 8'h01);
      read_check("st_rd_1ff", 9'h1FF, 8'hFF);

      // reset mid-fill, late byte, then a fresh sector
      send_cmd(32'h0000_0050);
      tick();
      for (int i = 0; i < 300; i++) stream_byte(8'h77, 1);
      reset_n = 1'b0;
      #1;
      check_reset_outputs();
      tick();
      reset_n = 1'b1;
      tick();
      stream_byte(8'h99, 1);
      chk("rm_late_busy", {31'd0, sif.busy}, 32'd0);
      chk("rm_late_valid", {31'd0, sif.sector_valid}, 32'd0);
      send_cmd(32'h0000_0060);
      tick();
      stream_sector(0, 8'h3C, 1);
      chk("rm_addr", sif.sd_address, 32'h60);
      read_check("rm_rd_000", 9'h000, 8'h3C);
      read_check("rm_rd_12c", 9'h12C, 8'h10);
      read_check("rm_rd_1ff", 9'h1FF, 8'hC3);

`ifdef SD_SECTOR_BUFFER_TIMEOUT_EN
      // stream stalls after 10 bytes
      send_cmd(32'h0000_0070);
      tick();
      for (int i = 0; i < 10; i++) stream_byte(8'(i), 1);
      repeat (998) tick();
      chk("to_busy_before", {31'd0, sif.busy}, 32'd1);
      tick();
      chk("to_busy", {31'd0, sif.busy}, 32'd0);
      chk("to_error", {31'd0, sif.error}, 32'd1);
      chk("to_valid", {31'd0, sif.sector_valid}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sd_sector_buffer.md
Name: sd_sector_buffer

Overview:
- Sits between sd_controller and the CPU bus decoder.
- Accepts a sector-read command, issues rd to the SD controller, and captures the 512-byte stream into block RAM.
- Presents the sector to the bus via a registered byte read port, with valid/busy/error status.
- Replaces the ad-hoc byte_index/sd_cache logic at board top.

Parameters:
- SECTOR_BYTES, 512, bytes captured per read command; must be a power of two.
- IDX_W, 9, index width; equals log2(SECTOR_BYTES).
- TIMEOUT_CYCLES, 25_000_000, idle-byte timeout in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset_n  in  1  asynchronous, active-low reset
- cmd_read  in  1  one-cycle pulse: start a sector read (bus write to Sdc_read)
- cmd_addr  in  32  sector address; sampled with cmd_read
- sd_ready  in  1  SD controller idle/ready
- sd_byte_available  in  1  SD controller byte strobe (level; may last several cycles)
- sd_dout  in  8  SD controller data byte
- sd_rd  out  1  read request to SD controller
- sd_address  out  32  latched sector address to SD controller
- rd_index  in  IDX_W  bus byte index (bus_address - Sdc_base)
- rd_data  out  8  buffer byte at rd_index, one cycle later
- sector_valid  out  1  full sector captured and unchanged since
- busy  out  1  command in progress
- error  out  1  sticky: command dropped or timeout; cleared by next accepted cmd_read

Behaviour:
- Reset values: sd_rd=0, sd_address=0, sector_valid=0, busy=0, error=0, rd_data=0, byte count=0, FSM=IDLE. Buffer contents are not reset.
- Reset asserted mid-operation aborts to IDLE immediately. A late SD byte is ignored.
- FSM states: IDLE, ISSUE, FILL, DONE.
- IDLE/DONE + cmd_read:
  - latch cmd_addr into sd_address;
  - clear sector_valid and error;
  - set count=0, busy=1;
  - go to ISSUE next cycle.
- ISSUE:
  - wait for sd_ready=1;
  - then drive sd_rd=1 for exactly one cycle and go to FILL;
  - sd_rd is never high outside ISSUE.
- Byte capture:
  - byte_av_d is a one-cycle delayed copy of sd_byte_available;
  - on a rising edge (sd_byte_available & ~byte_av_d) in FILL, write sd_dout to buf[count] and increment count;
  - a held strobe captures exactly one byte.
- FILL, capture of byte SECTOR_BYTES-1: go to DONE the following cycle with sector_valid=1 and busy=0. The count wraps to 0 and is not used again until the next command.
- Rising edges outside FILL: no write, no count change.
- cmd_read while busy (ISSUE/FILL): ignored; error set to 1; sd_address unchanged.
- Read port:
  - rd_data <= buf[rd_index] every cycle, latency 1;
  - read-first: a same-cycle write to the same index returns the old byte;
  - reads are allowed in any state; contents are meaningful only when sector_valid=1.
- Index arithmetic: rd_index is IDX_W bits; the caller truncates. No range checking.

Optional Feature:
- Macro: SD_SECTOR_BUFFER_TIMEOUT_EN.
- Enabled:
  - a 25-bit counter resets on entry to ISSUE and on each captured byte, and increments in ISSUE/FILL;
  - on reaching TIMEOUT_CYCLES: go to IDLE, busy=0, sector_valid=0, error=1.
- Disabled: no counter; the FSM waits in ISSUE/FILL indefinitely until reset.

Decomposition:
- Shared package (header.vh):
  - state encodings SSB_IDLE=2'd0, SSB_ISSUE=2'd1, SSB_FILL=2'd2, SSB_DONE=2'd3;
  - SD_SECTOR_BYTES=512;
  - the Sdc_base/Sdc_read addresses already defined there.
- One natural sub-module: ssb_byte_ram, a single-clock 1-write/1-read BRAM (read-first, registered output, no reset), so the buffer infers block RAM.

Test Plan:
- Normal read: cmd_read with cmd_addr=0x0000_0010, sd_ready=1; stream 512 bytes with value = index[7:0], each strobe held 4 cycles.
  - Required: one sd_rd pulse; sd_address=0x10; sector_valid=1 one cycle after the 512th edge;
  - rd_index=0x1FF gives rd_data=0xFF next cycle.
- Delayed ready: sd_ready=0 for 100 cycles after cmd_read. Required: sd_rd stays 0 and busy=1, then sd_rd pulses on the first ready cycle.
- Busy drop: second cmd_read (addr 0x20) at byte 100. Required: error=1, sd_address stays 0x10, capture completes normally.
- Stray and held strobes: 3 edges in IDLE, then one strobe held 50 cycles in FILL. Required: no writes in IDLE; count advances by exactly 1.
- Reset mid-fill: reset_n low at byte 300, then high, then a new cmd_read. Required: all outputs at reset values; new sector captured from index 0.
- With SD_SECTOR_BUFFER_TIMEOUT_EN and TIMEOUT_CYCLES=1000: stop the stream at byte 10. Required: at cycle 1000 after the last byte, FSM=IDLE, error=1, busy=0, sector_valid=0.
